// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, default
// parameter values and the counter width helper.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_STABLE  = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_RUN     = 3'd4
  } seq_state_e;

  localparam int DEF_N_CH        = 3;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_LOCK_STABLE = 64;
  localparam int DEF_HOLD_CYCLES = 1024;
  localparam int DEF_STEP_CYCLES = 16;

  // One counter serves every timed phase, so it is sized for the longest one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_sync.sv
// Single-bit multi-flop synchronizer with synchronous reset; used to bring
// the asynchronous lock and pushbutton inputs into the clock domain.
module rst_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the chain; reset clears every stage.
  // NOTE: synchronizer flops are reset to 0 so "good" cannot be seen until
  // the input has been observed for the full chain depth after reset.
  always_ff @(posedge clock) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Power-on / pushbutton reset sequencer: waits for a stable PLL lock and
// released external reset, holds all channels in reset, then releases them
// one at a time in index order.
// Optional feature: define RST_SEQ_SOFTRST_EN to add the sw_rst_req input,
// which re-enters the hold phase from RUN without re-checking stability.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE = DEF_LOCK_STABLE,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            pll_locked,
  input  logic            ext_rst_n,
`ifdef RST_SEQ_SOFTRST_EN
  input  logic            sw_rst_req,
`endif
  output logic [N_CH-1:0] rst_n,
  output logic            seq_done,
  output logic [2:0]      state
);

  localparam int CNT_W = cnt_width(LOCK_STABLE, HOLD_CYCLES, STEP_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_TC = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_TC = CNT_W'(STEP_CYCLES - 1);

  logic             pll_sync;
  logic             ext_sync;
  logic             good;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  rst_n_q, rst_n_d;
  logic             done_q, done_d;
  logic [N_CH-1:0]  rst_n_next_rel;

  rst_sync #(.STAGES(SYNC_STAGES)) u_sync_pll (
    .clock (clock),
    .reset (reset),
    .d     (pll_locked),
    .q     (pll_sync)
  );

  rst_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .clock (clock),
    .reset (reset),
    .d     (ext_rst_n),
    .q     (ext_sync)
  );

  assign good = pll_sync & ext_sync;

  // Next release pattern: shift in one more 1 above the already released bits.
  assign rst_n_next_rel = (rst_n_q << 1) | N_CH'(1);

  // State, counter and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; a fault always takes priority.
  // NOTE: every target gets a default first so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;

    if (state_q != ST_ASSERT && !good) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          cnt_d   = '0;
          rst_n_d = '0;
          done_d  = 1'b0;
          if (good) state_d = ST_STABLE;
        end

        ST_STABLE: begin
          if (cnt_q >= LOCK_TC) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_HOLD: begin
          if (cnt_q >= HOLD_TC) begin
            cnt_d   = '0;
            rst_n_d = rst_n_next_rel;
            if (&rst_n_next_rel) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt_q >= STEP_TC) begin
            cnt_d   = '0;
            rst_n_d = rst_n_next_rel;
            if (&rst_n_next_rel) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_RUN: begin
          cnt_d = '0;
`ifdef RST_SEQ_SOFTRST_EN
          if (sw_rst_req) begin
            state_d = ST_HOLD;
            rst_n_d = '0;
            done_d  = 1'b0;
          end
`endif
        end

        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          rst_n_d = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign rst_n    = rst_n_q;
  assign seq_done = done_q;
  assign state    = state_q;

endmodule
